fifo_sync_32x8: RTL and testbench



---
 rtl/fifo_sync_32x8.sv | 130 +++++++++++++
 tb/tb_fifo_sync_32x8.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_32x8.sv
// 32-entry x 8-bit synchronous show-ahead FIFO with edge-detected WRITE/READ strobes.
// Defining FIFO_ASSERT_EN compiles a simulation-only overflow/underflow/occupancy checker.

module fifo_sync_32x8 (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       CLEAR_N,
  input  logic       WRITE,
  input  logic       READ,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       F_FULL_N,
  output logic       F_EMPTY_N,
  output logic [4:0] USE_DW
);

  logic [7:0] mem_r [32];
  logic [4:0] wr_ptr_r;
  logic [4:0] rd_ptr_r;
  logic [5:0] count_r;
  logic       wr_q_r;
  logic       rd_q_r;

  logic       wr_ev_s;
  logic       rd_ev_s;
  logic       full_s;
  logic       empty_s;
  logic       do_wr_s;
  logic       do_rd_s;
  logic [5:0] count_next_s;

  // Request edge detection and operation qualification
  always_comb begin
    wr_ev_s = WRITE & ~wr_q_r;
    rd_ev_s = READ & ~rd_q_r;
    full_s  = (count_r == 6'd32);
    empty_s = (count_r == 6'd0);
    do_rd_s = rd_ev_s & ~empty_s;
    // a write while full is legal only when a read frees the slot in the same edge
    do_wr_s = wr_ev_s & (~full_s | do_rd_s);
  end

  // Occupancy update for the qualified operations
  always_comb begin
    count_next_s = count_r;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_next_s = count_r + 6'd1;
      2'b01:   count_next_s = count_r - 6'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer, count and strobe-history registers
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r <= 5'd0;
      rd_ptr_r <= 5'd0;
      count_r  <= 6'd0;
      wr_q_r   <= 1'b0;
      rd_q_r   <= 1'b0;
    end else begin
      wr_q_r <= WRITE;
      rd_q_r <= READ;
      if (!CLEAR_N) begin
        wr_ptr_r <= 5'd0;
        rd_ptr_r <= 5'd0;
        count_r  <= 6'd0;
      end else begin
        if (do_wr_s) begin
          wr_ptr_r <= wr_ptr_r + 5'd1;
        end
        if (do_rd_s) begin
          rd_ptr_r <= rd_ptr_r + 5'd1;
        end
        count_r <= count_next_s;
      end
    end
  end

  // Storage array; contents survive flush and reset
  always_ff @(posedge CLOCK) begin
    if (RESET_N && CLEAR_N && do_wr_s) begin
      mem_r[wr_ptr_r] <= DATA_IN;
    end
  end

  // Show-ahead data and status flags
  always_comb begin
    if (empty_s) begin
      DATA_OUT = 8'h00;
    end else begin
      DATA_OUT = mem_r[rd_ptr_r];
    end
    F_EMPTY_N = ~empty_s;
    F_FULL_N  = ~full_s;
    USE_DW    = count_r[4:0];
  end

`ifdef FIFO_ASSERT_EN
  fifo_sync_32x8_chk u_chk (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .wr_ev (wr_ev_s),
    .rd_ev (rd_ev_s),
    .count (count_r)
  );
`endif

endmodule

`ifdef FIFO_ASSERT_EN
module fifo_sync_32x8_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       wr_ev,
  input logic       rd_ev,
  input logic [5:0] count
);

  // Overflow, underflow and occupancy-range monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (wr_ev && !rd_ev && count == 6'd32) $error("fifo_sync_32x8: overflow");
      if (rd_ev && count == 6'd0) $error("fifo_sync_32x8: underflow");
      if (count > 6'd32) $error("fifo_sync_32x8: count out of range");
    end
  end

endmodule
`endif

// File: tb/tb_fifo_sync_32x8.sv
// Directed self-checking bench for fifo_sync_32x8: inputs change and outputs are sampled 1 ns after each rising edge.

module tb_fifo_sync_32x8;

  logic       CLOCK;
  logic       RESET_N;
  logic       CLEAR_N;
  logic       WRITE;
  logic       READ;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       F_FULL_N;
  logic       F_EMPTY_N;
  logic [4:0] USE_DW;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_sync_32x8 dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .CLEAR_N   (CLEAR_N),
    .WRITE     (WRITE),
    .READ      (READ),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .F_FULL_N  (F_FULL_N),
    .F_EMPTY_N (F_EMPTY_N),
    .USE_DW    (USE_DW)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    WRITE = 1'b1;
    DATA_IN = d;
    tick();
    WRITE = 1'b0;
    tick();
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    chk(tag, DATA_OUT, exp);
    READ = 1'b1;
    tick();
    READ = 1'b0;
    tick();
  endtask

  initial begin
    RESET_N = 1'b0;
    CLEAR_N = 1'b1;
    WRITE   = 1'b0;
    READ    = 1'b0;
    DATA_IN = 8'd0;
    tick();
    chk("rst_full_n", 8'(F_FULL_N), 8'd1);
    chk("rst_empty_n", 8'(F_EMPTY_N), 8'd0);
    chk("rst_use_dw", 8'(USE_DW), 8'd0);
    chk("rst_data", DATA_OUT, 8'd0);
    tick();
    RESET_N = 1'b1;
    tick();

    // read on empty is ignored
    READ = 1'b1;
    tick();
    tick();
    READ = 1'b0;
    tick();
    chk("urd_empty_n", 8'(F_EMPTY_N), 8'd0);
    chk("urd_full_n", 8'(F_FULL_N), 8'd1);
    chk("urd_use_dw", 8'(USE_DW), 8'd0);
    chk("urd_data", DATA_OUT, 8'd0);

    // held WRITE gives exactly one write
    WRITE = 1'b1;
    DATA_IN = 8'd11;
    tick();
    tick();
    tick();
    WRITE = 1'b0;
    repeat (4) tick();
    chk("hold_use_dw", 8'(USE_DW), 8'd1);
    chk("hold_empty_n", 8'(F_EMPTY_N), 8'd1);
    READ = 1'b1;
    #1;
    chk("hold_showahead", DATA_OUT, 8'd11);
    tick();
    chk("hold_rd_use_dw", 8'(USE_DW), 8'd0);
    chk("hold_rd_empty_n", 8'(F_EMPTY_N), 8'd0);
    chk("hold_rd_data", DATA_OUT, 8'd0);
    READ = 1'b0;
    tick();

    // fill to 32, overflow attempt, drain in order
    for (int i = 0; i < 32; i++) wr(8'(i));
    chk("full_full_n", 8'(F_FULL_N), 8'd0);
    chk("full_use_dw", 8'(USE_DW), 8'd0);
    chk("full_empty_n", 8'(F_EMPTY_N), 8'd1);
    chk("full_head", DATA_OUT, 8'd0);
    wr(8'd99);
    chk("ovf_full_n", 8'(F_FULL_N), 8'd0);
    chk("ovf_use_dw", 8'(USE_DW), 8'd0);
    for (int i = 0; i < 32; i++) rd($sformatf("drain_%0d", i), 8'(i));
    chk("drain_empty_n", 8'(F_EMPTY_N), 8'd0);
    chk("drain_use_dw", 8'(USE_DW), 8'd0);
    chk("drain_data", DATA_OUT, 8'd0);

    // flush
    for (int i = 0; i < 20; i++) wr(8'(100 + i));
    chk("pre_clr_use_dw", 8'(USE_DW), 8'd20);
    chk("pre_clr_head", DATA_OUT, 8'd100);
    CLEAR_N = 1'b0;
    tick();
    CLEAR_N = 1'b1;
    chk("clr_use_dw", 8'(USE_DW), 8'd0);
    chk("clr_empty_n", 8'(F_EMPTY_N), 8'd0);
    chk("clr_data", DATA_OUT, 8'd0);
    wr(8'd7);
    chk("post_clr_data", DATA_OUT, 8'd7);
    chk("post_clr_use_dw", 8'(USE_DW), 8'd1);

    // simultaneous write and read with 5 stored (7,1,2,3,4)
    for (int i = 1; i < 5; i++) wr(8'(i));
    chk("sim_pre_use_dw", 8'(USE_DW), 8'd5);
    WRITE = 1'b1;
    READ = 1'b1;
    DATA_IN = 8'd42;
    tick();
    WRITE = 1'b0;
    READ = 1'b0;
    tick();
    chk("sim_use_dw", 8'(USE_DW), 8'd5);
    for (int i = 1; i < 5; i++) rd($sformatf("sim_rd_%0d", i), 8'(i));
    chk("sim_42", DATA_OUT, 8'd42);
    chk("sim_left_use_dw", 8'(USE_DW), 8'd1);
    rd("sim_rd_42", 8'd42);
    chk("sim_end_empty_n", 8'(F_EMPTY_N), 8'd0);

    // asynchronous reset mid-cycle
    wr(8'd50);
    wr(8'd51);
    wr(8'd52);
    chk("pre_arst_use_dw", 8'(USE_DW), 8'd3);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("arst_use_dw", 8'(USE_DW), 8'd0);
    chk("arst_empty_n", 8'(F_EMPTY_N), 8'd0);
    chk("arst_full_n", 8'(F_FULL_N), 8'd1);
    chk("arst_data", DATA_OUT, 8'd0);

    // strobe held through reset release acts at the first edge
    WRITE = 1'b1;
    DATA_IN = 8'd77;
    tick();
    chk("inrst_use_dw", 8'(USE_DW), 8'd0);
    RESET_N = 1'b1;
    tick();
    chk("rel_use_dw", 8'(USE_DW), 8'd1);
    chk("rel_data", DATA_OUT, 8'd77);
    WRITE = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
